// File: rtl/enemy_wave_scheduler.sv
// Wave sequencer for the fly/spider/mosquito enemy groups: timed spawn pulses,
// wave-clear detection and the IDLE/SPAWN/PLAY/GAP/OVER/CLEAR game flow.
module enemy_wave_scheduler #(
    parameter int ENEMY_COUNT  = 23,
    parameter int GAP_FRAMES   = 120,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                   i_clk25,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_vsync,
    input  logic                   i_player_hit,
    input  logic [ENEMY_COUNT-1:0] i_enemy_alive_flat,
    output logic                   o_reset_fly,
    output logic                   o_reset_spider,
    output logic                   o_reset_mosquito,
    output logic [1:0]             o_wave,
    output logic [2:0]             o_state,
    output logic                   o_game_over,
    output logic                   o_game_clear
);

    localparam int FW = $clog2(GAP_FRAMES + 1);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [FW-1:0] GAP_LAST   = FW'(GAP_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_PLAY  = 3'd2,
        S_GAP   = 3'd3,
        S_OVER  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    state_t          r_state;
    logic [1:0]      r_wave;
    logic [PW-1:0]   r_pulse_cnt;
    logic [FW-1:0]   r_frame_cnt;
    logic            r_armed;
    logic            r_start_s;
    logic            r_start_d;
    logic            r_vsync_d;
    logic [2:0]      r_pulse;
    logic            r_game_over;
    logic            r_game_clear;

    logic            w_start_edge;
    logic            w_frame_tick;
    logic [2:0]      w_grp_dead;
    logic            w_cur_dead;

    assign w_start_edge = r_start_s & ~r_start_d;
    assign w_frame_tick = ~i_vsync & r_vsync_d;

    for (genvar gi = 0; gi < 3; gi++) begin : g_grp
        localparam int LO = (gi == 0) ? 0  : (gi == 1) ? 17 : 21;
        localparam int HI = (gi == 0) ? 16 : (gi == 1) ? 20 : 22;
        assign w_grp_dead[gi] = ~|i_enemy_alive_flat[HI:LO];
    end

    always_comb begin
        w_cur_dead = 1'b0;
        case (r_wave)
            2'd0:    w_cur_dead = w_grp_dead[0];
            2'd1:    w_cur_dead = w_grp_dead[1];
            default: w_cur_dead = w_grp_dead[2];
        endcase
    end

    function automatic logic [2:0] pulse_sel(input logic [1:0] wave);
        return 3'b001 << wave;
    endfunction

    // Start samplers come out of reset as "pressed" so a button held through
    // reset release must be let go before it can start a game.
    always_ff @(posedge i_clk25 or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wave       <= 2'd0;
            r_pulse_cnt  <= '0;
            r_frame_cnt  <= '0;
            r_armed      <= 1'b0;
            r_start_s    <= 1'b1;
            r_start_d    <= 1'b1;
            r_vsync_d    <= 1'b1;
            r_pulse      <= 3'b000;
            r_game_over  <= 1'b0;
            r_game_clear <= 1'b0;
        end else begin
            r_start_s <= i_start;
            r_start_d <= r_start_s;
            r_vsync_d <= i_vsync;
            case (r_state)
                S_IDLE, S_OVER, S_CLEAR: begin
                    if (w_start_edge) begin
                        r_state      <= S_SPAWN;
                        r_wave       <= 2'd0;
                        r_pulse_cnt  <= '0;
                        r_frame_cnt  <= '0;
                        r_armed      <= 1'b0;
                        r_pulse      <= pulse_sel(2'd0);
                        r_game_over  <= 1'b0;
                        r_game_clear <= 1'b0;
                    end
                end
                S_SPAWN: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        r_state     <= S_PLAY;
                        r_pulse     <= 3'b000;
                        r_armed     <= 1'b0;
                        r_pulse_cnt <= '0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + PW'(1);
                    end
                end
                S_PLAY: begin
                    // Arming waits one frame so the controllers can raise alive bits.
                    if (w_frame_tick) r_armed <= 1'b1;
                    if (i_player_hit) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end else if (r_armed && w_cur_dead) begin
                        if (r_wave == 2'd2) begin
                            r_state      <= S_CLEAR;
                            r_game_clear <= 1'b1;
                        end else begin
                            r_state     <= S_GAP;
                            r_frame_cnt <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (i_player_hit) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end else if (w_frame_tick) begin
                        if (r_frame_cnt == GAP_LAST) begin
                            r_state     <= S_SPAWN;
                            r_wave      <= r_wave + 2'd1;
                            r_frame_cnt <= '0;
                            r_pulse_cnt <= '0;
                            r_pulse     <= pulse_sel(r_wave + 2'd1);
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_reset_fly      = r_pulse[0];
    assign o_reset_spider   = r_pulse[1];
    assign o_reset_mosquito = r_pulse[2];
    assign o_wave           = r_wave;
    assign o_state          = r_state;
    assign o_game_over      = r_game_over;
    assign o_game_clear     = r_game_clear;

endmodule
